// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss BCD stopwatch.
//   state_t          - control FSM states (IDLE / RUN / PAUSE)
//   bcd_t            - one 4-bit BCD digit
//   DIGIT_MAX_UNITS  - highest value of a units digit (9)
//   DIGIT_MAX_TENS   - highest value of a tens digit (5)
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX_UNITS = 4'd9;
  localparam bcd_t DIGIT_MAX_TENS  = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch count chain.
// Ports:
//   clk_in - system clock
//   rst    - synchronous active-high reset, digit -> 0
//   clr    - synchronous clear, digit -> 0
//   inc    - advance the digit by one this cycle
//   q      - registered digit value, 0..MAX
//   carry  - combinational: inc while the digit sits at MAX (it rolls to 0)
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX_UNITS
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  bcd_t r_q;

  // Anything at or above MAX rolls to 0, so the digit can never sit
  // outside its BCD range even if it somehow got there.
  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (inc) begin
      if (r_q >= MAX) r_q <= '0;
      else            r_q <= r_q + 4'd1;
    end
  end

  assign q     = r_q;
  assign carry = inc & (r_q == MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// Minute/second stopwatch fed by the lab clock divider.
// The divided square wave is edge-detected into a one-cycle enable, divided
// by TICKS_PER_SEC in a prescaler, and the resulting one-second step advances
// a four-digit BCD mm:ss chain under a start/pause/clear FSM.
// Ports:
//   clk_in     - system clock (only clock)
//   rst        - synchronous active-high reset
//   tick_in    - divider output level; only rising edges count
//   start_stop - one-cycle pulse, toggles run/pause (IDLE starts running)
//   clear      - one-cycle pulse, returns to IDLE at 00:00
//   sec_lo, sec_hi, min_lo, min_hi - registered BCD digits
//   running    - high while in RUN
//   wrap       - one-cycle pulse when the count rolls 59:59 -> 00:00
//   dbg_state  - current FSM state, for observation only
// Event priority: rst > clear > start_stop > step.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       running,
  output logic       wrap,
  output logic [1:0] dbg_state
);

  localparam logic [9:0] PRE_LAST = 10'(TICKS_PER_SEC - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_tick_q;
  logic [9:0] r_pre;
  logic       r_wrap;

  logic       w_edge;
  logic       w_in_run;
  logic       w_pre_done;
  logic       w_step;
  logic       w_c_sec_lo;
  logic       w_c_sec_hi;
  logic       w_c_min_lo;
  logic       w_c_min_hi;

  // ---------------------------------------------------------------------
  // Edge detector. tick_q comes out of reset high so a divider output that
  // is already high when reset releases is not mistaken for a new edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) r_tick_q <= 1'b1;
    else     r_tick_q <= tick_in;
  end

  assign w_edge   = tick_in & ~r_tick_q;
  assign w_in_run = (r_state == RUN);

  // ---------------------------------------------------------------------
  // Prescaler: counts edges only while running and holds across a pause,
  // so a resumed count continues the partial second.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst || clear) begin
      r_pre <= '0;
    end else if (w_in_run && w_edge) begin
      if (r_pre >= PRE_LAST) r_pre <= '0;
      else                   r_pre <= r_pre + 10'd1;
    end
  end

  assign w_pre_done = w_in_run & w_edge & (r_pre >= PRE_LAST);

  // A start_stop or clear in the same cycle wins over the step; the
  // completed second is dropped rather than shown after the pause.
  assign w_step = w_pre_done & ~start_stop & ~clear;

  // ---------------------------------------------------------------------
  // Control FSM: state register / next-state / outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else if (start_stop) begin
      case (r_state)
        IDLE:    w_state_next = RUN;
        RUN:     w_state_next = PAUSE;
        PAUSE:   w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Both outputs are pure decodes of the state register, so they carry no
  // combinational path from any input.
  always_comb begin
    running   = (r_state == RUN);
    dbg_state = r_state;
  end

  // ---------------------------------------------------------------------
  // Digit chain. The carry ripples through all four digits in one cycle.
  // ---------------------------------------------------------------------
  bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_sec_lo (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (clear),
    .inc    (w_step),
    .q      (sec_lo),
    .carry  (w_c_sec_lo)
  );

  bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_sec_hi (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (clear),
    .inc    (w_c_sec_lo),
    .q      (sec_hi),
    .carry  (w_c_sec_hi)
  );

  bcd_digit #(.MAX(DIGIT_MAX_UNITS)) u_min_lo (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (clear),
    .inc    (w_c_sec_hi),
    .q      (min_lo),
    .carry  (w_c_min_lo)
  );

  bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_min_hi (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (clear),
    .inc    (w_c_min_lo),
    .q      (min_hi),
    .carry  (w_c_min_hi)
  );

  // The top-digit carry is exactly the step taken at 59:59, so registering
  // it lines the pulse up with the cycle the digits first read 00:00.
  always_ff @(posedge clk_in) begin
    if (rst || clear) r_wrap <= 1'b0;
    else              r_wrap <= w_c_min_hi;
  end

  assign wrap = r_wrap;

endmodule
